// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the lfsr_gen operand source.
// Holds the FSM encoding, the default feedback mask and the single-step function.
// The step function works at a fixed maximum width so every WIDTH can share it.
package lfsr_pkg;

  // Widest LFSR the shared step function supports.
  localparam int unsigned LFSR_MAX_W = 64;

  // Default feedback mask for the 8-bit configuration.
  localparam logic [7:0] LFSR_DEF_TAPS = 8'h1B;

  typedef enum logic {
    GEN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One Fibonacci step: right shift, parity of the tapped bits enters bit width-1.
  // Bits of state at or above width are expected to be zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           width
  );
    logic [LFSR_MAX_W-1:0] w_fb;
    w_fb = LFSR_MAX_W'(^(state & taps));
    return (state >> 1) | (w_fb << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr_gen_step.sv
// Purpose: combinational single-step next-state of a Fibonacci LFSR.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller decides when the result is registered.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS)
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  // Widen into the shared helper, step once, trim back to the register width.
  assign o_next = WIDTH'(lfsr_next(LFSR_MAX_W'(i_state), LFSR_MAX_W'(TAPS), WIDTH));

endmodule

// File: rtl/lfsr_gen.sv
// Purpose: pseudo-random operand source, Fibonacci LFSR with seed load and lock-up recovery.
// Latency: first word STEPS enabled cycles after reset/load; STEPS=1 gives one word per cycle.
// Backpressure: valid/ready; word and LFSR are frozen while out_valid=1 and out_ready=0.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      OUT_W = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
  parameter int unsigned      STEPS = 1,
  parameter int unsigned      CNT_W = 16
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lockup,
  output logic [CNT_W-1:0] word_count
);

  // step_cnt only needs to reach STEPS-1.
  localparam int unsigned    SC_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEPS - 1);

  state_t           r_fsm,      w_fsm_nxt;
  logic [WIDTH-1:0] r_state,    w_state_nxt;
  logic [SC_W-1:0]  r_step_cnt, w_cnt_nxt;
  logic [OUT_W-1:0] r_data,     w_data_nxt;
  logic             r_vld,      w_vld_nxt;
  logic             r_lock,     w_lock_nxt;
  logic [CNT_W-1:0] r_wc,       w_wc_nxt;
  logic [WIDTH-1:0] w_next;

  // Single next-state block shared by the GEN step and the HOLD handshake step.
  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .i_state (r_state),
    .o_next  (w_next)
  );

  // Next-state logic: load first, then the GEN/HOLD advance, then zero-state recovery.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_step_cnt;
    w_data_nxt  = r_data;
    w_vld_nxt   = r_vld;
    w_wc_nxt    = r_wc;
    w_lock_nxt  = 1'b0;
    if (load) begin
      // A handshake in the same cycle is dropped: no word counted, no advance.
      w_state_nxt = seed;
      w_cnt_nxt   = '0;
      w_vld_nxt   = 1'b0;
      w_fsm_nxt   = GEN;
      if (seed == '0) begin
        w_state_nxt = '1;
        w_lock_nxt  = 1'b1;
      end
    end else begin
      case (r_fsm)
        GEN: begin
          if (en) begin
            w_state_nxt = w_next;
            if (r_step_cnt == SC_LAST) begin
              w_data_nxt = w_next[OUT_W-1:0];
              w_vld_nxt  = 1'b1;
              w_cnt_nxt  = '0;
              w_fsm_nxt  = HOLD;
            end else begin
              w_cnt_nxt = r_step_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // The handshake advance ignores en; it counts as step 0 of the next word.
          if (r_vld && out_ready) begin
            w_wc_nxt    = r_wc + 1'b1;
            w_state_nxt = w_next;
            if (STEPS == 1) begin
              w_data_nxt = w_next[OUT_W-1:0];
            end else begin
              w_cnt_nxt = SC_W'(1);
              w_vld_nxt = 1'b0;
              w_fsm_nxt = GEN;
            end
          end
        end
        default: begin
          w_fsm_nxt = GEN;
        end
      endcase
      // An all-zero register would never leave zero; force it back to all ones.
      if (r_state == '0) begin
        w_state_nxt = '1;
        w_lock_nxt  = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_fsm      <= GEN;
      r_state    <= '1;
      r_step_cnt <= '0;
      r_data     <= '0;
      r_vld      <= 1'b0;
      r_lock     <= 1'b0;
      r_wc       <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_state    <= w_state_nxt;
      r_step_cnt <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_vld      <= w_vld_nxt;
      r_lock     <= w_lock_nxt;
      r_wc       <= w_wc_nxt;
    end
  end

  assign out_data   = r_data;
  assign out_valid  = r_vld;
  assign lockup     = r_lock;
  assign word_count = r_wc;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a STEPS=1 instance and a STEPS=3, 3-bit-counter instance share inputs.
// A word-level model tracks both; hand-computed literals pin the model to known sequences.
module tb_lfsr_gen;

  logic       Clk;
  logic       nRst;
  logic       en;
  logic       load;
  logic [7:0] seed;
  logic       out_ready;

  logic [2:0]  d1_data;
  logic        d1_valid;
  logic        d1_lock;
  logic [15:0] d1_wc;
  logic [2:0]  d3_data;
  logic        d3_valid;
  logic        d3_lock;
  logic [2:0]  d3_wc;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  lfsr_gen #(.WIDTH(8), .OUT_W(3), .TAPS(8'h1B), .STEPS(1), .CNT_W(16)) u_dut1 (
    .Clk(Clk), .nRst(nRst), .en(en), .load(load), .seed(seed),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .lockup(d1_lock), .word_count(d1_wc)
  );

  lfsr_gen #(.WIDTH(8), .OUT_W(3), .TAPS(8'h1B), .STEPS(3), .CNT_W(3)) u_dut3 (
    .Clk(Clk), .nRst(nRst), .en(en), .load(load), .seed(seed),
    .out_data(d3_data), .out_valid(d3_valid), .out_ready(out_ready),
    .lockup(d3_lock), .word_count(d3_wc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: index 0 is the STEPS=1 instance, index 1 the STEPS=3 instance.
  logic [7:0] m_st   [2];
  logic [2:0] m_dat  [2];
  logic       m_vld  [2];
  logic       m_lock [2];
  int         m_wc   [2];
  int         m_togo [2];

  function automatic logic [7:0] m_step(input logic [7:0] s);
    int ones;
    logic [7:0] taps;
    taps = 8'h1B;
    ones = 0;
    for (int i = 0; i < 8; i++) if (s[i] && taps[i]) ones++;
    return (s >> 1) + (((ones % 2) == 1) ? 8'h80 : 8'h00);
  endfunction

  task automatic m_reset(input int k, input int steps);
    m_st[k] = 8'hFF; m_dat[k] = 3'd0; m_vld[k] = 1'b0;
    m_lock[k] = 1'b0; m_wc[k] = 0; m_togo[k] = steps;
  endtask

  task automatic m_update(input int k, input int steps, input int wmod);
    logic [7:0] cur;
    logic [7:0] nx;
    cur = m_st[k];
    nx  = m_step(cur);
    m_lock[k] = 1'b0;
    if (load) begin
      m_vld[k]  = 1'b0;
      m_togo[k] = steps;
      if (seed == 8'h00) begin
        m_st[k] = 8'hFF; m_lock[k] = 1'b1;
      end else begin
        m_st[k] = seed;
      end
    end else begin
      if (m_vld[k]) begin
        if (out_ready) begin
          m_wc[k] = (m_wc[k] + 1) % wmod;
          m_st[k] = nx;
          if (steps == 1) m_dat[k] = nx[2:0];
          else begin
            m_vld[k]  = 1'b0;
            m_togo[k] = steps - 1;
          end
        end
      end else if (en) begin
        m_st[k]   = nx;
        m_togo[k] = m_togo[k] - 1;
        if (m_togo[k] == 0) begin
          m_dat[k] = nx[2:0];
          m_vld[k] = 1'b1;
        end
      end
      if (cur == 8'h00) begin
        m_st[k] = 8'hFF; m_lock[k] = 1'b1;
      end
    end
  endtask

  // Advance the model on every clock, reset it asynchronously like the DUT.
  always @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      m_reset(0, 1);
      m_reset(1, 3);
    end else begin
      m_update(0, 1, 65536);
      m_update(1, 3, 8);
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge Clk) begin
    if (cmp_on && nRst === 1'b1) begin
      chk("d1_valid", 32'(d1_valid), 32'(m_vld[0]));
      chk("d1_lockup", 32'(d1_lock), 32'(m_lock[0]));
      chk("d1_word_count", 32'(d1_wc), m_wc[0]);
      chk("d1_state", 32'(u_dut1.r_state), 32'(m_st[0]));
      if (m_vld[0]) chk("d1_data", 32'(d1_data), 32'(m_dat[0]));
      chk("d3_valid", 32'(d3_valid), 32'(m_vld[1]));
      chk("d3_lockup", 32'(d3_lock), 32'(m_lock[1]));
      chk("d3_word_count", 32'(d3_wc), m_wc[1]);
      chk("d3_state", 32'(u_dut3.r_state), 32'(m_st[1]));
      if (m_vld[1]) chk("d3_data", 32'(d3_data), 32'(m_dat[1]));
    end
  end

  logic [7:0] exp_st  [6];
  logic [2:0] exp_dat [6];
  logic       exp_v3  [6];

  initial begin
    exp_st  = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h87, 8'h43};
    exp_dat = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd3};
    exp_v3  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    nRst = 1'b0; en = 1'b0; load = 1'b0; seed = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset_valid", 32'(d1_valid), 32'd0);
    chk("reset_data", 32'(d1_data), 32'd0);
    chk("reset_lockup", 32'(d1_lock), 32'd0);
    chk("reset_wc", 32'(d1_wc), 32'd0);
    chk("reset_state", 32'(u_dut1.r_state), 32'hFF);

    // Reset sequence with en and out_ready held high.
    nRst = 1'b1; en = 1'b1; out_ready = 1'b1; cmp_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("seq_state", 32'(u_dut1.r_state), 32'(exp_st[i]));
      chk("seq_d1_data", 32'(d1_data), 32'(exp_dat[i]));
      chk("seq_d1_valid", 32'(d1_valid), 32'd1);
      chk("seq_d3_valid", 32'(d3_valid), 32'(exp_v3[i]));
    end
    chk("seq_d1_wc", 32'(d1_wc), 32'd5);
    chk("seq_d3_wc", 32'(d3_wc), 32'd1);

    // Seed load coincident with a pending handshake on both instances.
    load = 1'b1; seed = 8'h01;
    @(negedge Clk);
    chk("load_state", 32'(u_dut1.r_state), 32'h01);
    chk("load_d1_valid", 32'(d1_valid), 32'd0);
    chk("load_d1_wc", 32'(d1_wc), 32'd5);
    chk("load_d3_wc", 32'(d3_wc), 32'd1);
    load = 1'b0;
    @(negedge Clk);
    chk("seed1_state0", 32'(u_dut1.r_state), 32'h80);
    chk("seed1_data0", 32'(d1_data), 32'd0);
    chk("seed1_valid0", 32'(d1_valid), 32'd1);
    @(negedge Clk);
    chk("seed1_state1", 32'(u_dut1.r_state), 32'h40);
    chk("seed1_data1", 32'(d1_data), 32'd0);
    chk("seed1_wc", 32'(d1_wc), 32'd6);

    // Back-pressure: nothing moves while out_ready is low.
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      chk("bp_state", 32'(u_dut1.r_state), 32'h40);
      chk("bp_data", 32'(d1_data), 32'd0);
      chk("bp_valid", 32'(d1_valid), 32'd1);
      chk("bp_wc", 32'(d1_wc), 32'd6);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    chk("bp_accept_wc", 32'(d1_wc), 32'd7);
    chk("bp_accept_state", 32'(u_dut1.r_state), 32'h20);
    out_ready = 1'b0;
    @(negedge Clk);
    chk("bp_single_wc", 32'(d1_wc), 32'd7);

    // Lock-up: zero seed is replaced by all ones with a one-cycle pulse.
    load = 1'b1; seed = 8'h00; out_ready = 1'b1;
    @(negedge Clk);
    chk("lock_pulse_d1", 32'(d1_lock), 32'd1);
    chk("lock_pulse_d3", 32'(d3_lock), 32'd1);
    chk("lock_state", 32'(u_dut1.r_state), 32'hFF);
    chk("lock_load_wc", 32'(d1_wc), 32'd7);
    load = 1'b0;
    @(negedge Clk);
    chk("lock_end", 32'(d1_lock), 32'd0);
    chk("lock_resume_state", 32'(u_dut1.r_state), 32'h7F);
    chk("lock_resume_data", 32'(d1_data), 32'd7);

    // STEPS=3 stall: en low mid-word freezes the GEN instance, HOLD instance keeps going.
    en = 1'b0;
    repeat (3) @(negedge Clk);
    chk("stall_d3_state", 32'(u_dut3.r_state), 32'h7F);
    chk("stall_d3_valid", 32'(d3_valid), 32'd0);
    chk("stall_d1_state", 32'(u_dut1.r_state), 32'h0F);
    en = 1'b1;
    repeat (2) @(negedge Clk);
    chk("stall_d3_word", 32'(d3_data), 32'd7);
    chk("stall_d3_vld", 32'(d3_valid), 32'd1);
    chk("stall_d3_st", 32'(u_dut3.r_state), 32'h1F);

    // Mixed en/ready pattern with a mid-run load; the 3-bit counter wraps here.
    for (int i = 0; i < 48; i++) begin
      en        = (i % 5) != 4;
      out_ready = (i % 3) != 0;
      load      = (i == 24);
      seed      = 8'hA5;
      @(negedge Clk);
    end
    load = 1'b0;

    // Asynchronous reset between edges while holding a word.
    en = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    chk("pre_areset_valid", 32'(d1_valid), 32'd1);
    #2 nRst = 1'b0;
    #1;
    chk("areset_valid", 32'(d1_valid), 32'd0);
    chk("areset_data", 32'(d1_data), 32'd0);
    chk("areset_lockup", 32'(d1_lock), 32'd0);
    chk("areset_wc", 32'(d1_wc), 32'd0);
    chk("areset_state", 32'(u_dut1.r_state), 32'hFF);
    chk("areset_d3_valid", 32'(d3_valid), 32'd0);
    chk("areset_d3_wc", 32'(d3_wc), 32'd0);
    @(negedge Clk);
    nRst = 1'b1; out_ready = 1'b1;
    @(negedge Clk);
    chk("rerun_state", 32'(u_dut1.r_state), 32'h7F);
    chk("rerun_data", 32'(d1_data), 32'd7);
    chk("rerun_valid", 32'(d1_valid), 32'd1);
    repeat (3) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
